// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding a UART core: circular FIFO plus launch/track FSM.
// Optional CR-before-LF insertion when UART_TXQ_CRLF_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH_LOG2     = 4,
  parameter int LAUNCH_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TW-1:0]         tmr;
  logic [7:0]            head;
  logic [7:0]            launch_byte;
  logic                  push;
  logic                  pop;
  logic                  launch;

  assign full   = count == DEPTH_C;
  assign empty  = count == '0;
  assign busy   = (state != S_IDLE) || !empty;
  assign head   = mem[rd_ptr];
  assign push   = wr_en && !full;
  assign launch = (state == S_IDLE) && !empty && !uart_is_transmitting;

`ifdef UART_TXQ_CRLF_EN
  logic cr_sent;
  logic cr_now;

  // An LF at the head is sent as CR first and stays queued for the next launch
  assign cr_now      = launch && (head == 8'h0A) && !cr_sent;
  assign pop         = launch && !cr_now;
  assign launch_byte = cr_now ? 8'h0D : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_sent <= 1'b0;
    end else if (cr_now) begin
      cr_sent <= 1'b1;
    end else if (launch) begin
      cr_sent <= 1'b0;
    end
  end
`else
  assign pop         = launch;
  assign launch_byte = head;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      tmr           <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            uart_tx_byte  <= launch_byte;
            uart_transmit <= 1'b1;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          uart_transmit <= 1'b0;
          tmr           <= TW'(LAUNCH_TIMEOUT);
          state         <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A UART that never reports busy costs the byte; no retry
          if (uart_is_transmitting) begin
            state <= S_WAIT_DONE;
          end else if (tmr <= TW'(1)) begin
            state <= S_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
